// File: rtl/serdes.sv
// serdes: 32-bit single-lane serializer/deserializer, single clock domain.
// Ports: clock, reset_n (async, active-low), enable, load, tx_data[31:0],
//   tx_serial, rx_serial, rx_data[31:0], rx_valid, frame_err.
// Option: define SERDES_LSB_FIRST_EN for LSB-first bit order (default MSB first).
module serdes (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        load,
    input  logic [31:0] tx_data,
    output logic        tx_serial,
    input  logic        rx_serial,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        frame_err
);

    logic [31:0] tx_sh;
    logic [31:0] tx_shift;
    logic [31:0] rx_sh;
    logic [31:0] rx_next;
    logic [5:0]  bit_cnt;
    logic        primed;

`ifdef SERDES_LSB_FIRST_EN
    assign tx_serial = tx_sh[0];
    assign tx_shift  = {1'b0, tx_sh[31:1]};
    assign rx_next   = {rx_serial, rx_sh[31:1]};
`else
    assign tx_serial = tx_sh[31];
    assign tx_shift  = {tx_sh[30:0], 1'b0};
    assign rx_next   = {rx_sh[30:0], rx_serial};
`endif

    // Status pulses clear on every edge so they last exactly one cycle,
    // even if enable drops right after the load edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_sh     <= '0;
            rx_sh     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            bit_cnt   <= '0;
            primed    <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (enable) begin
                if (load) begin
                    tx_sh   <= tx_data;
                    rx_data <= rx_next;
                    rx_sh   <= '0;
                    bit_cnt <= '0;
                    primed  <= 1'b1;
                    if (primed) begin
                        if (bit_cnt == 6'd31) rx_valid <= 1'b1;
                        else                  frame_err <= 1'b1;
                    end
                end else begin
                    tx_sh <= tx_shift;
                    rx_sh <= rx_next;
                    if (bit_cnt != 6'd32) bit_cnt <= bit_cnt + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serdes.sv
// tb_serdes: loopback bench for serdes with a queue-based line model.
// Checks tx_serial, rx_data, rx_valid and frame_err after every edge.
module tb_serdes;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        load;
    logic [31:0] tx_data;
    logic        tx_serial;
    logic        rx_serial;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        frame_err;

    int n_cmp = 0;
    int n_bad = 0;

    assign rx_serial = tx_serial;

    always #5 clock = ~clock;

    serdes dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .load      (load),
        .tx_data   (tx_data),
        .tx_serial (tx_serial),
        .rx_serial (rx_serial),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    // Model: the word being sent, how many bits have left since its load,
    // and every line bit the receiver sampled since the last load.
    logic [31:0] m_word;
    logic [31:0] m_data;
    bit          m_loaded;
    bit          m_primed;
    bit          m_valid;
    bit          m_err;
    int          m_k;
    bit          m_q[$];

    task automatic model_reset();
        m_word   = '0;
        m_data   = '0;
        m_loaded = 0;
        m_primed = 0;
        m_valid  = 0;
        m_err    = 0;
        m_k      = 0;
        m_q.delete();
    endtask

    function automatic logic m_tx();
        if (!m_loaded || m_k >= 32) return 1'b0;
`ifdef SERDES_LSB_FIRST_EN
        return m_word[m_k];
`else
        return m_word[31 - m_k];
`endif
    endfunction

    // Word built from the most recent 32 sampled bits, oldest first on the line.
    function automatic logic [31:0] assemble();
        logic [31:0] v;
        int n;
        v = '0;
        n = m_q.size();
        for (int i = (n > 32) ? n - 32 : 0; i < n; i++) begin
`ifdef SERDES_LSB_FIRST_EN
            v = {logic'(m_q[i]), v[31:1]};
`else
            v = {v[30:0], logic'(m_q[i])};
`endif
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp,
                   $time);
        end
    endtask

    task automatic compare_all();
        check("tx_serial", {31'b0, tx_serial}, {31'b0, m_tx()});
        check("rx_data", rx_data, m_data);
        check("rx_valid", {31'b0, rx_valid}, {31'b0, m_valid});
        check("frame_err", {31'b0, frame_err}, {31'b0, m_err});
    endtask

    task automatic step(input logic en, input logic ld,
                        input logic [31:0] d);
        logic line;
        enable  = en;
        load    = ld;
        tx_data = d;
        line    = m_tx();
        @(posedge clock);
        #1;
        m_valid = 0;
        m_err   = 0;
        if (!reset_n) begin
            model_reset();
        end else if (en) begin
            m_q.push_back(line);
            if (ld) begin
                m_data = assemble();
                if (m_primed) begin
                    if (m_q.size() == 32) m_valid = 1;
                    else                  m_err   = 1;
                end
                m_primed = 1;
                m_loaded = 1;
                m_word   = d;
                m_k      = 0;
                m_q.delete();
            end else if (m_k < 32) begin
                m_k++;
            end
        end
        compare_all();
    endtask

    // One nominal frame: load, then 31 shifts; optional 7-cycle stall.
    task automatic frame(input logic [31:0] w, input int stall_at);
        step(1'b1, 1'b1, w);
        for (int i = 1; i < 32; i++) begin
            if (i == stall_at) begin
                repeat (7) step(1'b0, 1'($urandom), $urandom);
            end
            step(1'b1, 1'b0, $urandom);
        end
    endtask

    initial begin
        model_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        load    = 1'b0;
        tx_data = '0;
        #1;
        compare_all();
        repeat (4) step(1'b1, 1'($urandom), $urandom);
        reset_n = 1'b1;

        frame(32'h12345678, -1);
        frame(32'hA5A50F0F, -1);
        frame(32'hDEADBEEF, -1);

        step(1'b1, 1'b1, 32'hFFFFFFFF);
        repeat (19) step(1'b1, 1'b0, $urandom);
        step(1'b1, 1'b1, 32'h00000000);
        repeat (31) step(1'b1, 1'b0, $urandom);

        for (int f = 0; f < 6; f++) begin
            frame($urandom, (f % 2 == 1) ? int'($urandom_range(1, 30)) : -1);
        end

        step(1'b1, 1'b1, $urandom);
        repeat (40) step(1'b1, 1'b0, $urandom);
        frame($urandom, -1);
        frame($urandom, 12);

        step(1'b1, 1'b1, $urandom);
        repeat (10) step(1'b1, 1'b0, $urandom);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        step(1'b1, 1'b1, $urandom);
        reset_n = 1'b1;
        frame($urandom, -1);
        frame($urandom, -1);
        step(1'b1, 1'b1, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
